osc_frame_packer: RTL and testbench



---
 rtl/osc_pkg.sv | 45 ++++
 rtl/osc_sample_fifo.sv | 55 +++++
 rtl/osc_frame_packer.sv | 212 +++++++++++++++++++++
 tb/tb_osc_frame_packer.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope frame packer.
//   state_t     : frame-level FSM states (which byte of the frame is current)
//   phase_t     : byte handshake phase inside a byte state
//   SYNC_BYTE_DEFAULT : default first byte of every frame
//   frame_bytes : total bytes on the wire per frame (sync + seq + 2/sample + csum)
//   clog2       : ceiling log2 for pointer/count sizing
package osc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_SEQ  = 3'd2,
        ST_HI   = 3'd3,
        ST_LO   = 3'd4,
        ST_CSUM = 3'd5
    } state_t;

    // FETCH only occurs in ST_HI: the FIFO read issued on entry is valid here.
    // HOLD keeps the byte valid until the transmitter reports busy; RELEASE
    // waits for the transmitter to go idle before the next byte.
    typedef enum logic [1:0] {
        PH_FETCH   = 2'd0,
        PH_HOLD    = 2'd1,
        PH_RELEASE = 2'd2
    } phase_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic int frame_bytes(input int frame_len);
        return 2 * frame_len + 3;
    endfunction

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/osc_sample_fifo.sv
// Single-clock sample FIFO with registered read.
//   clock, reset  : system clock, synchronous active-high reset (empties FIFO)
//   write_en/data : write request; ignored while full
//   read_en       : pop request; read_data is valid the cycle after the pop
//   count         : occupancy, one bit wider than the address
//   full, empty   : occupancy flags derived from count
module osc_sample_fifo
    import osc_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 128
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    write_en,
    input  logic [WIDTH-1:0]        write_data,
    input  logic                    read_en,
    output logic [WIDTH-1:0]        read_data,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_write;
    logic             do_read;

    // Extra wrap bit on each pointer lets full and empty be told apart.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign do_write = write_en && !full;
    assign do_read  = read_en && !empty;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (do_read)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= write_data;
        if (do_read)  read_data <= mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/osc_frame_packer.sv
// Packs buffered ADC samples into framed byte packets for the UART transmitter:
//   SYNC_BYTE, seq, {hi, lo} per sample, checksum (mod-256 sum of seq..last lo).
//   i_Clock, i_Reset : system clock, synchronous active-high reset
//   i_Sample_DV/i_Sample : sample write into the internal FIFO
//   i_TX_Active      : transmitter busy flag
//   o_TX_DV/o_TX_Byte: level-held byte valid and byte to the transmitter
//   o_Busy           : frame in progress
//   o_Overflow       : sticky, a sample arrived while the FIFO was full
//   o_Frame_Seq      : sequence number of the next frame to send
module osc_frame_packer
    import osc_pkg::*;
#(
    parameter int         SAMPLE_WIDTH = 12,
    parameter int         FRAME_LEN    = 64,
    parameter int         FIFO_DEPTH   = 128,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Sample_DV,
    input  logic [SAMPLE_WIDTH-1:0] i_Sample,
    input  logic                    i_TX_Active,
    output logic                    o_TX_DV,
    output logic [7:0]              o_TX_Byte,
    output logic                    o_Busy,
    output logic                    o_Overflow,
    output logic [7:0]              o_Frame_Seq
);

    localparam int          AW          = clog2(FIFO_DEPTH);
    localparam logic [AW:0] FRAME_LEN_C = FRAME_LEN[AW:0];
    localparam logic [7:0]  LAST_IDX    = 8'(FRAME_LEN - 1);

    // Upper sample bits, zero-padded to a byte (SAMPLE_WIDTH <= 16).
    function automatic logic [7:0] hi_byte(input logic [SAMPLE_WIDTH-1:0] s);
        return 8'(s >> 8);
    endfunction

    state_t state, state_next;
    phase_t phase, phase_next;

    logic [SAMPLE_WIDTH-1:0] fifo_rd_data;
    logic [AW:0]             fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_pop;

    logic [7:0] sample_lo_p0;
    logic [7:0] csum;
    logic [7:0] sample_cnt;

    logic       pop_req;
    logic       load_byte;
    logic [7:0] byte_next;
    logic       dv_clr;
    logic       capture;
    logic       csum_clr;
    logic       csum_add;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       seq_inc;

    osc_sample_fifo #(
        .WIDTH (SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (i_Clock),
        .reset      (i_Reset),
        .write_en   (i_Sample_DV),
        .write_data (i_Sample),
        .read_en    (fifo_pop),
        .read_data  (fifo_rd_data),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign fifo_pop = pop_req && !fifo_empty;
    assign o_Busy   = (state != ST_IDLE);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= ST_IDLE;
            phase <= PH_HOLD;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    always_comb begin
        state_next = state;
        phase_next = phase;
        pop_req    = 1'b0;
        load_byte  = 1'b0;
        byte_next  = o_TX_Byte;
        dv_clr     = 1'b0;
        capture    = 1'b0;
        csum_clr   = 1'b0;
        csum_add   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        seq_inc    = 1'b0;

        if (state == ST_IDLE) begin
            // Only start once the whole frame is buffered, so the frame never stalls on data.
            if ((fifo_count >= FRAME_LEN_C) && !i_TX_Active) begin
                state_next = ST_SYNC;
                phase_next = PH_HOLD;
                load_byte  = 1'b1;
                byte_next  = SYNC_BYTE;
                csum_clr   = 1'b1;
                cnt_clr    = 1'b1;
            end
        end else begin
            case (phase)
                PH_FETCH: begin
                    capture    = 1'b1;
                    load_byte  = 1'b1;
                    byte_next  = hi_byte(fifo_rd_data);
                    phase_next = PH_HOLD;
                end
                PH_HOLD: begin
                    if (i_TX_Active) begin
                        dv_clr     = 1'b1;
                        phase_next = PH_RELEASE;
                        csum_add   = (state != ST_SYNC) && (state != ST_CSUM);
                    end
                end
                PH_RELEASE: begin
                    if (!i_TX_Active) begin
                        case (state)
                            ST_SYNC: begin
                                state_next = ST_SEQ;
                                phase_next = PH_HOLD;
                                load_byte  = 1'b1;
                                byte_next  = o_Frame_Seq;
                            end
                            ST_SEQ: begin
                                state_next = ST_HI;
                                phase_next = PH_FETCH;
                                pop_req    = 1'b1;
                            end
                            ST_HI: begin
                                state_next = ST_LO;
                                phase_next = PH_HOLD;
                                load_byte  = 1'b1;
                                byte_next  = sample_lo_p0;
                            end
                            ST_LO: begin
                                if (sample_cnt == LAST_IDX) begin
                                    state_next = ST_CSUM;
                                    phase_next = PH_HOLD;
                                    load_byte  = 1'b1;
                                    byte_next  = csum;
                                end else begin
                                    state_next = ST_HI;
                                    phase_next = PH_FETCH;
                                    pop_req    = 1'b1;
                                    cnt_inc    = 1'b1;
                                end
                            end
                            ST_CSUM: begin
                                state_next = ST_IDLE;
                                phase_next = PH_HOLD;
                                seq_inc    = 1'b1;
                            end
                            default: begin
                                state_next = ST_IDLE;
                                phase_next = PH_HOLD;
                            end
                        endcase
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    phase_next = PH_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_TX_DV     <= 1'b0;
            o_TX_Byte   <= 8'h00;
            o_Overflow  <= 1'b0;
            o_Frame_Seq <= 8'h00;
            sample_cnt  <= 8'h00;
        end else begin
            if (load_byte) begin
                o_TX_Byte <= byte_next;
                o_TX_DV   <= 1'b1;
            end else if (dv_clr) begin
                o_TX_DV   <= 1'b0;
            end
            // Full is the pre-pop flag, so a write in a full cycle drops even with a pop.
            if (i_Sample_DV && fifo_full) o_Overflow <= 1'b1;
            if (seq_inc) o_Frame_Seq <= o_Frame_Seq + 8'd1;
            if (cnt_clr)      sample_cnt <= 8'h00;
            else if (cnt_inc) sample_cnt <= sample_cnt + 8'd1;
        end
    end

    // ---- stage p0: captured sample low byte and running checksum ----
    always_ff @(posedge i_Clock) begin
        if (capture) sample_lo_p0 <= fifo_rd_data[7:0];
        if (csum_clr)      csum <= 8'h00;
        else if (csum_add) csum <= csum + o_TX_Byte;
    end

endmodule

// File: tb/tb_osc_frame_packer.sv
`timescale 1ns/1ps
module tb_osc_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_dv;
    logic [11:0] sample;
    logic        tx_active;
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        overflow;
    logic [7:0]  frame_seq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q [$];
    int rise_delay = 1;
    bit stall = 1'b0;

    typedef enum {M_IDLE, M_RISE, M_HIGH} mstate_t;
    mstate_t m_state = M_IDLE;
    int m_cnt = 0;

    always #5 clk = ~clk;

    osc_frame_packer #(
        .SAMPLE_WIDTH (12),
        .FRAME_LEN    (4),
        .FIFO_DEPTH   (8),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_Sample_DV (sample_dv),
        .i_Sample    (sample),
        .i_TX_Active (tx_active),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .o_Busy      (busy),
        .o_Overflow  (overflow),
        .o_Frame_Seq (frame_seq)
    );

    // Transmitter model: takes the byte when it sees DV, raises active
    // rise_delay cycles later, holds it for 10 cycles.
    initial begin
        tx_active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_active = 1'b0;
                m_state   = M_IDLE;
            end else if (stall) begin
                tx_active = 1'b1;
            end else begin
                case (m_state)
                    M_IDLE: begin
                        tx_active = 1'b0;
                        if (tx_dv) begin
                            rx_q.push_back(tx_byte);
                            m_cnt   = rise_delay;
                            m_state = M_RISE;
                        end
                    end
                    M_RISE: begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt <= 0) begin
                            tx_active = 1'b1;
                            m_cnt     = 10;
                            m_state   = M_HIGH;
                        end
                    end
                    default: begin
                        m_cnt = m_cnt - 1;
                        if (m_cnt <= 0) begin
                            tx_active = 1'b0;
                            m_state   = M_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rst       = 1'b1;
        sample_dv = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_one(input logic [11:0] v);
        sample_dv = 1'b1;
        sample    = v;
        @(negedge clk);
        sample_dv = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int budget, output bit ok);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sample_dv = 1'b0;
        sample    = 12'h000;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_dv !== 1'b0)       begin n_fail++; $display("FAIL reset_tx_dv: got %b expected 0", tx_dv); end
        n_checks++; if (tx_byte !== 8'h00)    begin n_fail++; $display("FAIL reset_tx_byte: got %02h expected 00", tx_byte); end
        n_checks++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_checks++; if (frame_seq !== 8'h00)  begin n_fail++; $display("FAIL reset_seq: got %02h expected 00", frame_seq); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx_dv !== 1'b0)       begin n_fail++; $display("FAIL reset_idle_dv: got %b expected 0", tx_dv); end
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [11];
        int base;
        bit ok;
        exp  = '{8'hA5, 8'h00, 8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC, 8'hD4};
        base = rx_q.size();
        write_one(12'h123);
        write_one(12'h456);
        write_one(12'h789);
        write_one(12'hABC);
        wait_bytes(base + 11, 400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL basic_timeout: got %0d bytes expected 11", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    n_fail++; $display("FAIL basic_byte%0d: got %02h expected %02h", i, rx_q[base+i], exp[i]);
                end
            end
        end
        wait_idle(60);
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL basic_busy: got %b expected 0", busy); end
        n_checks++; if (frame_seq !== 8'h01) begin n_fail++; $display("FAIL basic_seq: got %02h expected 01", frame_seq); end
    endtask

    task automatic test_threshold();
        logic [7:0] exp [11];
        int base;
        int c;
        bit ok;
        exp  = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h0F, 8'hFF, 8'h15};
        base = rx_q.size();
        write_one(12'h001);
        write_one(12'h002);
        write_one(12'h003);
        repeat (20) @(negedge clk);
        n_checks++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL thresh_3_dv: got %b expected 0", tx_dv); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL thresh_3_busy: got %b expected 0", busy); end
        write_one(12'hFFF);
        c = 0;
        while (!tx_dv && c < 2) begin
            @(negedge clk);
            c++;
        end
        n_checks++; if (tx_dv !== 1'b1) begin n_fail++; $display("FAIL thresh_start: got dv %b after %0d cycles expected 1", tx_dv, c); end
        wait_bytes(base + 11, 400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL thresh_timeout: got %0d bytes expected 11", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    n_fail++; $display("FAIL thresh_byte%0d: got %02h expected %02h", i, rx_q[base+i], exp[i]);
                end
            end
        end
        wait_idle(60);
    endtask

    task automatic test_overflow();
        logic [7:0] exp [22];
        int base;
        bit ok;
        exp = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h03, 8'h01, 8'h04, 8'h0E,
                8'hA5, 8'h01, 8'h01, 8'h05, 8'h01, 8'h06, 8'h01, 8'h07, 8'h01, 8'h08, 8'h1F};
        apply_reset();
        stall = 1'b1;
        repeat (2) @(negedge clk);
        base = rx_q.size();
        for (int i = 0; i < 8; i++) write_one(12'h101 + 12'(i));
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_at_full: got %b expected 0", overflow); end
        write_one(12'h109);
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        n_checks++; if (tx_dv !== 1'b0)    begin n_fail++; $display("FAIL ovf_stalled_dv: got %b expected 0", tx_dv); end
        stall = 1'b0;
        wait_bytes(base + 22, 800, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL ovf_timeout: got %0d bytes expected 22", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 22; i++) begin
                n_checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    n_fail++; $display("FAIL ovf_byte%0d: got %02h expected %02h", i, rx_q[base+i], exp[i]);
                end
            end
        end
        repeat (60) @(negedge clk);
        n_checks++; if (rx_q.size() != base + 22) begin n_fail++; $display("FAIL ovf_extra_bytes: got %0d expected 22", rx_q.size() - base); end
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL ovf_busy: got %b expected 0", busy); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_seq_wrap();
        int base;
        bit ok;
        apply_reset();
        for (int f = 0; f < 257; f++) begin
            base = rx_q.size();
            for (int s = 0; s < 4; s++) write_one(12'h000);
            wait_bytes(base + 11, 400, ok);
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL wrap_timeout: frame %0d got %0d bytes expected 11", f, rx_q.size() - base);
                break;
            end
            if (f == 255) begin
                n_checks++; if (rx_q[base+1] !== 8'hFF)  begin n_fail++; $display("FAIL wrap_seq_ff: got %02h expected FF", rx_q[base+1]); end
                n_checks++; if (rx_q[base+10] !== 8'hFF) begin n_fail++; $display("FAIL wrap_csum_ff: got %02h expected FF", rx_q[base+10]); end
            end
            if (f == 256) begin
                n_checks++; if (rx_q[base+1] !== 8'h00)  begin n_fail++; $display("FAIL wrap_seq_00: got %02h expected 00", rx_q[base+1]); end
                n_checks++; if (rx_q[base+10] !== 8'h00) begin n_fail++; $display("FAIL wrap_csum_00: got %02h expected 00", rx_q[base+10]); end
            end
        end
        wait_idle(60);
        n_checks++; if (frame_seq !== 8'h01) begin n_fail++; $display("FAIL wrap_seq_after: got %02h expected 01", frame_seq); end
    endtask

    task automatic test_handshake_hold();
        logic [7:0] exp [11];
        logic [7:0] b0;
        int base;
        int c;
        int hold_errs;
        bit ok;
        exp = '{8'hA5, 8'h00, 8'h00, 8'hAA, 8'h00, 8'hBB, 8'h00, 8'hCC, 8'h00, 8'hDD, 8'h0E};
        apply_reset();
        rise_delay = 50;
        base = rx_q.size();
        write_one(12'h0AA);
        write_one(12'h0BB);
        write_one(12'h0CC);
        write_one(12'h0DD);
        c = 0;
        while (!tx_dv && c < 5) begin
            @(negedge clk);
            c++;
        end
        b0 = tx_byte;
        n_checks++; if (b0 !== 8'hA5) begin n_fail++; $display("FAIL hold_first_byte: got %02h expected A5", b0); end
        hold_errs = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_dv !== 1'b1 || tx_byte !== b0) hold_errs++;
        end
        n_checks++; if (hold_errs != 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", hold_errs); end
        wait_bytes(base + 11, 900, ok);
        wait_idle(100);
        repeat (20) @(negedge clk);
        n_checks++; if (rx_q.size() != base + 11) begin n_fail++; $display("FAIL hold_count: got %0d bytes expected 11", rx_q.size() - base); end
        if (ok) begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    n_fail++; $display("FAIL hold_byte%0d: got %02h expected %02h", i, rx_q[base+i], exp[i]);
                end
            end
        end
        rise_delay = 1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] pre [5];
        logic [7:0] exp [11];
        int base;
        bit ok;
        pre = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h02};
        exp = '{8'hA5, 8'h00, 8'h05, 8'h55, 8'h06, 8'h66, 8'h07, 8'h77, 8'h08, 8'h88, 8'hD4};
        apply_reset();
        base = rx_q.size();
        write_one(12'h111);
        write_one(12'h222);
        write_one(12'h333);
        write_one(12'h444);
        wait_bytes(base + 5, 200, ok);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout: got %0d bytes expected 5", rx_q.size() - base); end
        n_checks++; if (tx_dv !== 1'b0)      begin n_fail++; $display("FAIL rmid_dv: got %b expected 0", tx_dv); end
        n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_checks++; if (frame_seq !== 8'h00) begin n_fail++; $display("FAIL rmid_seq: got %02h expected 00", frame_seq); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        if (ok) begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (rx_q[base+i] !== pre[i]) begin
                    n_fail++; $display("FAIL rmid_pre%0d: got %02h expected %02h", i, rx_q[base+i], pre[i]);
                end
            end
        end
        base = rx_q.size();
        write_one(12'h555);
        write_one(12'h666);
        repeat (30) @(negedge clk);
        n_checks++; if (tx_dv !== 1'b0) begin n_fail++; $display("FAIL rmid_fifo_empty: got dv %b expected 0", tx_dv); end
        write_one(12'h777);
        write_one(12'h888);
        wait_bytes(base + 11, 400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL rmid_new_timeout: got %0d bytes expected 11", rx_q.size() - base);
        end else begin
            for (int i = 0; i < 11; i++) begin
                n_checks++;
                if (rx_q[base+i] !== exp[i]) begin
                    n_fail++; $display("FAIL rmid_byte%0d: got %02h expected %02h", i, rx_q[base+i], exp[i]);
                end
            end
        end
        wait_idle(60);
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_threshold();
        test_overflow();
        test_handshake_hold();
        test_reset_mid_frame();
        test_seq_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
